// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush, forwarding view and stall counter.
// mem_ready comes from a flop, so there is no combinational path from wb_ready back to MEM.
module mem_wb_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WE_W   = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [WE_W-1:0]   mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [PC_W-1:0]   mem_pc,
    input  logic [OP_W-1:0]   mem_aluop,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [WE_W-1:0]   wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [PC_W-1:0]   wb_pc,
    output logic [OP_W-1:0]   wb_aluop,
    output logic [WE_W-1:0]   fwd_hit_mask,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PW = ADDR_W + WE_W + DATA_W + PC_W + OP_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     skid_q, skid_d;
    logic              mem_ready_q, mem_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [PW-1:0]     entry_in;
    logic [WE_W-1:0]   head_wreg;
    logic              acc;
    logic              pop;

    assign entry_in = {mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop};
    assign {wb_wd, head_wreg, wb_wdata, wb_pc, wb_aluop} = head_q;

    assign wb_valid     = (state_q != EMPTY);
    assign wb_wreg      = wb_valid ? head_wreg : '0;
    assign fwd_hit_mask = wb_wreg & {WE_W{wb_wd != '0}};
    assign mem_ready    = mem_ready_q;
    assign stall_cnt    = stall_cnt_q;

    assign acc = mem_valid && mem_ready_q;
    assign pop = wb_valid && wb_ready;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        head_d  = entry_in;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (pop && acc) begin
                        head_d = entry_in;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end else if (acc) begin
                        skid_d  = entry_in;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Ready for next cycle is decided here so the output is a plain flop.
        mem_ready_d = (state_d != TWO);

        if (wb_valid && !wb_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            mem_ready_q <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            mem_ready_q <= mem_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: a table of per-cycle vectors plus hand sequences for
// reset, no-bypass, stall-counter saturation and asynchronous reset mid-cycle.
module tb_mem_wb_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wd;
    logic [3:0]  mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [7:0]  mem_aluop;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_wd;
    logic [3:0]  wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic [7:0]  wb_aluop;
    logic [3:0]  fwd_hit_mask;
    logic [3:0]  stall_cnt;

    int n_vec;
    int n_bad;

    mem_wb_skid #(
        .DATA_W(32),
        .ADDR_W(5),
        .WE_W  (4),
        .PC_W  (32),
        .OP_W  (8),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_pc      (mem_pc),
        .mem_aluop   (mem_aluop),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .wb_pc       (wb_pc),
        .wb_aluop    (wb_aluop),
        .fwd_hit_mask(fwd_hit_mask),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        mv;
        logic        rdy;
        logic [4:0]  wd;
        logic [3:0]  wreg;
        logic [31:0] data;
        logic        ev;
        logic        er;
        logic [4:0]  ewd;
        logic [31:0] edata;
        logic [3:0]  ewreg;
        logic [3:0]  efwd;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic fl, input logic mv, input logic rdy,
                                input logic [4:0] wd, input logic [3:0] wreg,
                                input logic [31:0] data, input logic ev, input logic er,
                                input logic [4:0] ewd, input logic [31:0] edata,
                                input logic [3:0] ewreg, input logic [3:0] efwd,
                                input logic [3:0] ecnt);
        vec_t v;
        v.fl = fl; v.mv = mv; v.rdy = rdy; v.wd = wd; v.wreg = wreg; v.data = data;
        v.ev = ev; v.er = er; v.ewd = ewd; v.edata = edata; v.ewreg = ewreg;
        v.efwd = efwd; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic logic [31:0] pc_of(input logic [31:0] d);
        return 32'h0000_1000 + d;
    endfunction

    function automatic logic [7:0] op_of(input logic [31:0] d);
        return d[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //            fl mv rdy wd     wreg  data      ev er ewd    edata     ewreg efwd cnt
        vt[0]  = mk(0, 1, 1, 5'd1, 4'hF, 32'h11, 1, 1, 5'd1, 32'h11, 4'hF, 4'hF, 4'd0);
        vt[1]  = mk(0, 1, 1, 5'd2, 4'hF, 32'h22, 1, 1, 5'd2, 32'h22, 4'hF, 4'hF, 4'd0);
        vt[2]  = mk(0, 1, 1, 5'd3, 4'hF, 32'h33, 1, 1, 5'd3, 32'h33, 4'hF, 4'hF, 4'd0);
        vt[3]  = mk(0, 0, 1, 5'd0, 4'h0, 32'h00, 0, 1, 5'd0, 32'h00, 4'h0, 4'h0, 4'd0);
        vt[4]  = mk(0, 1, 0, 5'd0, 4'hF, 32'h44, 1, 1, 5'd0, 32'h44, 4'hF, 4'h0, 4'd0);
        vt[5]  = mk(0, 0, 1, 5'd0, 4'h0, 32'h00, 0, 1, 5'd0, 32'h00, 4'h0, 4'h0, 4'd0);
        vt[6]  = mk(0, 1, 1, 5'd5, 4'h3, 32'h55, 1, 1, 5'd5, 32'h55, 4'h3, 4'h3, 4'd0);
        vt[7]  = mk(0, 1, 0, 5'd6, 4'hF, 32'hAA, 1, 0, 5'd5, 32'h55, 4'h3, 4'h3, 4'd1);
        vt[8]  = mk(0, 1, 0, 5'd7, 4'hF, 32'hBB, 1, 0, 5'd5, 32'h55, 4'h3, 4'h3, 4'd2);
        vt[9]  = mk(0, 1, 1, 5'd7, 4'hF, 32'hBB, 1, 1, 5'd6, 32'hAA, 4'hF, 4'hF, 4'd2);
        vt[10] = mk(0, 1, 1, 5'd7, 4'hF, 32'hBB, 1, 1, 5'd7, 32'hBB, 4'hF, 4'hF, 4'd2);
        vt[11] = mk(0, 0, 1, 5'd0, 4'h0, 32'h00, 0, 1, 5'd0, 32'h00, 4'h0, 4'h0, 4'd2);
        vt[12] = mk(0, 1, 0, 5'd8, 4'h1, 32'hC1, 1, 1, 5'd8, 32'hC1, 4'h1, 4'h1, 4'd2);
        vt[13] = mk(0, 1, 0, 5'd9, 4'h2, 32'hC2, 1, 0, 5'd8, 32'hC1, 4'h1, 4'h1, 4'd3);
        vt[14] = mk(1, 1, 0, 5'd9, 4'h4, 32'hC3, 0, 1, 5'd0, 32'h00, 4'h0, 4'h0, 4'd4);
        vt[15] = mk(0, 0, 0, 5'd0, 4'h0, 32'h00, 0, 1, 5'd0, 32'h00, 4'h0, 4'h0, 4'd4);
        vt[16] = mk(0, 1, 0, 5'd10, 4'hF, 32'hD1, 1, 1, 5'd10, 32'hD1, 4'hF, 4'hF, 4'd4);

        rst = 1'b0; flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b0;
        mem_wd = '0; mem_wreg = '0; mem_wdata = '0; mem_pc = '0; mem_aluop = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_fwd", 32'(fwd_hit_mask), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            flush     = vt[i].fl;
            mem_valid = vt[i].mv;
            wb_ready  = vt[i].rdy;
            mem_wd    = vt[i].wd;
            mem_wreg  = vt[i].wreg;
            mem_wdata = vt[i].data;
            mem_pc    = pc_of(vt[i].data);
            mem_aluop = op_of(vt[i].data);
            if (i == 0) begin
                #1;
                check("no_comb_bypass", 32'(wb_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vt[i].ev));
            check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vt[i].er));
            check($sformatf("v%0d_wb_wreg", i), 32'(wb_wreg), 32'(vt[i].ewreg));
            check($sformatf("v%0d_fwd", i), 32'(fwd_hit_mask), 32'(vt[i].efwd));
            check($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vt[i].ecnt));
            if (vt[i].ev) begin
                check($sformatf("v%0d_wb_wdata", i), wb_wdata, vt[i].edata);
                check($sformatf("v%0d_wb_wd", i), 32'(wb_wd), 32'(vt[i].ewd));
                check($sformatf("v%0d_wb_pc", i), wb_pc, pc_of(vt[i].edata));
                check($sformatf("v%0d_wb_aluop", i), 32'(wb_aluop), 32'(op_of(vt[i].edata)));
            end
        end

        // Head holds 0xD1 with WB stalled; counter starts at 4 and must stop at 15.
        mem_valid = 1'b0;
        wb_ready  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d_cnt", k), 32'(stall_cnt), (k + 5 > 15) ? 32'd15 : 32'(k + 5));
            check($sformatf("sat%0d_hold", k), wb_wdata, 32'hD1);
        end

        #3;
        rst = 1'b0;
        #1;
        check("arst_wb_valid", 32'(wb_valid), 32'd0);
        check("arst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("arst_wb_wdata", wb_wdata, 32'd0);
        check("arst_wb_pc", wb_pc, 32'd0);
        check("arst_fwd", 32'(fwd_hit_mask), 32'd0);
        check("arst_mem_ready", 32'(mem_ready), 32'd1);
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_empty", 32'(wb_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
